// File: rtl/clock_chime.sv
// Alarm clock back end: alarm time setting, alarm ring FSM with timeout,
// hourly chime and a single square-wave tone generator driving the buzzer.
module clock_chime #(
  parameter int LO_HALF   = 2,
  parameter int HI_HALF   = 1,
  parameter int RING_SECS = 60
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [3:0] sec_01,
  input  logic [3:0] sec_10,
  input  logic [3:0] min_01,
  input  logic [3:0] min_10,
  input  logic [3:0] hour_01,
  input  logic [3:0] hour_10,
  input  logic       alarm_min_inc,
  input  logic       alarm_hour_inc,
  input  logic       alarm_en,
  input  logic       alarm_stop,
  output logic [3:0] al_min_01,
  output logic [3:0] al_min_10,
  output logic [3:0] al_hour_01,
  output logic [3:0] al_hour_10,
  output logic       ringing,
  output logic       buzzer
);
  typedef enum logic {IDLE, RING} state_t;
  typedef enum logic [1:0] {T_OFF, T_LO, T_HI} tone_t;

  localparam int MAXH = (LO_HALF > HI_HALF) ? LO_HALF : HI_HALF;
  localparam int DW   = (MAXH < 2) ? 1 : $clog2(MAXH);
  localparam logic [7:0] RING_LIM = 8'(RING_SECS);

  state_t      state, state_nxt;
  logic [7:0]  ring_cnt, cnt_nxt;
  logic [3:0]  prev_sec;
  logic        primed;
  logic        sec_tick, match;
  tone_t       tone, tone_q;
  logic [DW-1:0] div, half_m1;

  // primed suppresses a spurious tick in the first cycle after reset
  assign sec_tick = primed & (sec_01 != prev_sec);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      prev_sec <= '0;
      primed   <= 1'b0;
    end else begin
      prev_sec <= sec_01;
      primed   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      al_min_01  <= '0;
      al_min_10  <= '0;
      al_hour_01 <= '0;
      al_hour_10 <= '0;
    end else begin
      if (alarm_min_inc) begin
        if (al_min_01 == 4'd9) begin
          al_min_01 <= '0;
          al_min_10 <= (al_min_10 == 4'd5) ? 4'd0 : al_min_10 + 4'd1;
        end else begin
          al_min_01 <= al_min_01 + 4'd1;
        end
      end
      if (alarm_hour_inc) begin
        if ({al_hour_10, al_hour_01} == 8'h23) begin
          al_hour_10 <= '0;
          al_hour_01 <= '0;
        end else if (al_hour_01 == 4'd9) begin
          al_hour_01 <= '0;
          al_hour_10 <= al_hour_10 + 4'd1;
        end else begin
          al_hour_01 <= al_hour_01 + 4'd1;
        end
      end
    end
  end

  assign match = ({al_hour_10, al_hour_01, al_min_10, al_min_01} ==
                  {hour_10, hour_01, min_10, min_01}) &&
                 (sec_10 == 4'd0) && (sec_01 == 4'd0) && sec_tick;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= IDLE;
      ring_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ring_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = ring_cnt;
    case (state)
      IDLE: if (match && alarm_en && !alarm_stop) begin
        state_nxt = RING;
        cnt_nxt   = '0;
      end
      RING: begin
        if (alarm_stop || !alarm_en || ring_cnt == RING_LIM) state_nxt = IDLE;
        else if (sec_tick) cnt_nxt = ring_cnt + 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ringing = (state == RING);

  // chime wins over the 1 s on / 1 s off alarm tone
  always_comb begin
    tone = T_OFF;
    if ({min_10, min_01} == 8'h59 && sec_10 == 4'd5 && sec_01 == 4'd9)
      tone = T_HI;
    else if ({min_10, min_01} == 8'h59 && sec_10 == 4'd5 && sec_01[0] &&
             sec_01 <= 4'd7)
      tone = T_LO;
    else if (state == RING && !sec_01[0])
      tone = T_LO;
  end

  assign half_m1 = (tone == T_HI) ? DW'(HI_HALF - 1) : DW'(LO_HALF - 1);

  // a new tone restarts the divider and opens with a full high half-period
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      div    <= '0;
      buzzer <= 1'b0;
      tone_q <= T_OFF;
    end else begin
      tone_q <= tone;
      if (tone == T_OFF) begin
        div    <= '0;
        buzzer <= 1'b0;
      end else if (tone != tone_q) begin
        div    <= '0;
        buzzer <= 1'b1;
      end else if (div == half_m1) begin
        div    <= '0;
        buzzer <= ~buzzer;
      end else begin
        div <= div + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_clock_chime.sv
// Directed bench for clock_chime: expected ring/tone per time step is queued
// on drive and popped when the buzzer window has been observed.
module tb_clock_chime;
  logic       clk = 1'b0, clr_n = 1'b0;
  logic [3:0] sec_01 = '0, sec_10 = '0, min_01 = '0, min_10 = '0;
  logic [3:0] hour_01 = '0, hour_10 = '0;
  logic       alarm_min_inc = 0, alarm_hour_inc = 0, alarm_en = 0, alarm_stop = 0;
  logic [3:0] al_min_01, al_min_10, al_hour_01, al_hour_10;
  logic       ringing, buzzer;

  clock_chime dut (
    .clk(clk), .clr_n(clr_n),
    .sec_01(sec_01), .sec_10(sec_10), .min_01(min_01), .min_10(min_10),
    .hour_01(hour_01), .hour_10(hour_10),
    .alarm_min_inc(alarm_min_inc), .alarm_hour_inc(alarm_hour_inc),
    .alarm_en(alarm_en), .alarm_stop(alarm_stop),
    .al_min_01(al_min_01), .al_min_10(al_min_10),
    .al_hour_01(al_hour_01), .al_hour_10(al_hour_10),
    .ringing(ringing), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  // tone classes: 0 silent, 1 low (2-clk halves), 2 high (1-clk halves), 3 other
  typedef struct { string tag; int ring; int tone; } exp_t;
  exp_t sb[$];
  int n_vec = 0, n_err = 0;

  task automatic cmp(input string tag, input int got, input int want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic apply(input int h, input int m, input int s,
                       input int ering, input int etone, input string tag);
    @(negedge clk);
    hour_10 = 4'(h / 10); hour_01 = 4'(h % 10);
    min_10  = 4'(m / 10); min_01  = 4'(m % 10);
    sec_10  = 4'(s / 10); sec_01  = 4'(s % 10);
    sb.push_back('{tag, ering, etone});
  endtask

  task automatic check_step();
    exp_t e;
    logic b[8];
    int r, cls;
    bit is_hi, is_lo, all0;
    repeat (2) @(posedge clk);
    r = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      b[k] = buzzer;
      if (k == 0) r = int'(ringing);
    end
    all0 = 1; is_hi = 1; is_lo = 1;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) all0 = 0;
      if (k >= 1 && b[k] == b[k-1]) is_hi = 0;
      if (k >= 2 && b[k] == b[k-2]) is_lo = 0;
    end
    cls = all0 ? 0 : is_hi ? 2 : is_lo ? 1 : 3;
    if (sb.size() == 0) begin
      cmp("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      cmp({e.tag, "_ring"}, r, e.ring);
      cmp({e.tag, "_tone"}, cls, e.tone);
    end
  endtask

  task automatic pulse(input logic m, input logic h, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); alarm_min_inc = m; alarm_hour_inc = h;
      @(negedge clk); alarm_min_inc = 0; alarm_hour_inc = 0;
    end
  endtask

  function automatic int al_time();
    return int'({al_hour_10, al_hour_01, al_min_10, al_min_01});
  endfunction

  initial begin
    repeat (3) @(posedge clk); #1;
    cmp("rst_ring", int'(ringing), 0);
    cmp("rst_buz", int'(buzzer), 0);
    cmp("rst_al", al_time(), 'h0000);
    @(negedge clk); clr_n = 1;

    // alarm setting wrap
    pulse(1, 0, 59); #1 cmp("min59", al_time(), 'h0059);
    pulse(1, 0, 1);  #1 cmp("min_wrap", al_time(), 'h0000);
    pulse(0, 1, 23); #1 cmp("hour23", al_time(), 'h2300);
    pulse(0, 1, 1);  #1 cmp("hour_wrap", al_time(), 'h0000);
    pulse(1, 1, 1);  #1 cmp("both_inc", al_time(), 'h0101);
    pulse(0, 1, 6); pulse(1, 0, 29); #1 cmp("set_0730", al_time(), 'h0730);

    // ring and timeout
    alarm_en = 1;
    apply(7, 29, 59, 0, 0, "pre"); check_step();
    apply(7, 30, 0, 1, 1, "s00");
    @(posedge clk); #1 cmp("ring_1cyc", int'(ringing), 1);
    check_step();
    for (int s = 1; s < 60; s++)
      begin apply(7, 30, s, 1, (s % 2) ? 0 : 1, $sformatf("s%0d", s)); check_step(); end
    apply(7, 31, 0, 0, 0, "timeout"); check_step();

    // stop and no re-trigger
    apply(7, 29, 59, 0, 0, "pre2"); check_step();
    apply(7, 30, 0, 1, 1, "ring2"); check_step();
    @(negedge clk); alarm_stop = 1;
    @(posedge clk); #1 cmp("stop_next", int'(ringing), 0);
    @(negedge clk); alarm_stop = 0;
    repeat (20) @(posedge clk); #1 cmp("no_retrig", int'(ringing), 0);

    // stop coincident with match wins
    apply(7, 29, 59, 0, 0, "pre3"); check_step();
    apply(7, 30, 0, 0, 0, "stop_match"); alarm_stop = 1;
    @(negedge clk); alarm_stop = 0;
    check_step();

    // disarm exits RING
    apply(7, 29, 59, 0, 0, "pre4"); check_step();
    apply(7, 30, 0, 1, 1, "ring4"); check_step();
    @(negedge clk); alarm_en = 0;
    @(posedge clk); #1 cmp("disarm", int'(ringing), 0);

    // hourly chime
    for (int s = 50; s < 60; s++)
      begin
        apply(12, 59, s, 0, (s == 59) ? 2 : (s % 2) ? 1 : 0, $sformatf("ch%0d", s));
        check_step();
      end
    apply(13, 0, 0, 0, 0, "ch_1300"); check_step();

    // chime over alarm
    pulse(0, 1, 5); pulse(1, 0, 29); #1 cmp("set_1259", al_time(), 'h1259);
    alarm_en = 1;
    apply(12, 58, 59, 0, 0, "pre5"); check_step();
    for (int s = 0; s < 60; s++)
      begin
        apply(12, 59, s, 1,
              (s == 59) ? 2 : (s >= 51 && s <= 57 && (s % 2)) ? 1 : (s % 2) ? 0 : 1,
              $sformatf("ov%0d", s));
        check_step();
      end

    // asynchronous reset while ringing with high tone active
    @(negedge clk); #2 clr_n = 0;
    #1;
    cmp("arst_ring", int'(ringing), 0);
    cmp("arst_buz", int'(buzzer), 0);
    cmp("arst_al", al_time(), 'h0000);
    @(negedge clk); clr_n = 1;
    apply(13, 0, 5, 0, 0, "post_rst"); check_step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
